// File: rtl/sonic_motion_anim_ctrl_pkg.sv
// Shared types and widths for the player sprite animation sequencer.
// Optional double jump is enabled by defining SONIC_DOUBLE_JUMP_EN.
package sonic_anim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        JUMP = 2'd2
    } anim_state_t;

    localparam int unsigned ROW_IDLE = 0;
    localparam int unsigned ROW_RUN  = 1;
    localparam int unsigned ROW_JUMP = 2;

    localparam int unsigned IDX_W = 2;
    localparam int unsigned DIV_W = 4;
    localparam int unsigned OFS_W = 10;
    localparam int unsigned POS_W = 12;
    localparam int unsigned VEL_W = 8;

    // Clamp a signed height to the 0..1023 screen displacement range
    function automatic logic [OFS_W-1:0] sat_pos(input logic signed [POS_W-1:0] p);
        logic [OFS_W-1:0] r;
        if (p[POS_W-1]) begin
            r = '0;
        end else if (|p[POS_W-2:OFS_W]) begin
            r = '1;
        end else begin
            r = p[OFS_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sonic_motion_anim_ctrl_if.sv
// Key inputs and sprite offset outputs of the animation sequencer.
interface sonic_motion_anim_ctrl_if;
    import sonic_anim_pkg::*;

    logic             frame_tick;
    logic             key_left;
    logic             key_right;
    logic             key_jump;
    logic [OFS_W-1:0] sprite_offset_x;
    logic [OFS_W-1:0] sprite_offset_y;
    logic [OFS_W-1:0] jump_pos_y;
    logic             facing_left;
    logic [1:0]       anim_state;

    modport master (
        output frame_tick, key_left, key_right, key_jump,
        input  sprite_offset_x, sprite_offset_y, jump_pos_y, facing_left, anim_state
    );

    modport slave (
        input  frame_tick, key_left, key_right, key_jump,
        output sprite_offset_x, sprite_offset_y, jump_pos_y, facing_left, anim_state
    );
endinterface

// File: rtl/sonic_motion_anim_ctrl_jump_physics.sv
// Vertical jump integrator: height/velocity registers, landing detect and
// saturated screen displacement.
module sonic_jump_physics
    import sonic_anim_pkg::*;
#(
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic             step,
    input  logic             launch,
    input  logic             reload,
    output logic             land_c,
    output logic [OFS_W-1:0] jump_pos_y
);

    logic signed [POS_W-1:0] pos_q, pos_n, pos_sum;
    logic signed [VEL_W-1:0] vel_q, vel_n;

    assign pos_sum = pos_q + POS_W'(vel_q);
    // Touchdown: falling and the next height would reach or pass the ground
    assign land_c  = step && vel_q[VEL_W-1] && (pos_sum[POS_W-1] || (pos_sum == '0));

    always_comb begin
        pos_n = pos_q;
        vel_n = vel_q;
        if (launch) begin
            pos_n = '0;
            vel_n = VEL_W'(JUMP_VEL);
        end else if (land_c) begin
            pos_n = '0;
            vel_n = '0;
        end else if (reload) begin
            vel_n = VEL_W'(JUMP_VEL);
        end else if (step) begin
            pos_n = pos_sum;
            vel_n = vel_q - VEL_W'(GRAVITY);
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_q      <= '0;
            vel_q      <= '0;
            jump_pos_y <= '0;
        end else begin
            pos_q      <= pos_n;
            vel_q      <= vel_n;
            jump_pos_y <= sat_pos(pos_n);
        end
    end

endmodule

// File: rtl/sonic_motion_anim_ctrl.sv
// Per-frame idle/run/jump sequencer producing sprite-sheet offsets, facing and
// jump height. Define SONIC_DOUBLE_JUMP_EN to allow one extra jump in the air.
module sonic_motion_anim_ctrl
    import sonic_anim_pkg::*;
#(
    parameter int unsigned FRAME_W  = 18,
    parameter int unsigned FRAME_H  = 32,
    parameter int          JUMP_VEL = 12,
    parameter int          GRAVITY  = 1,
    parameter int unsigned RUN_DIV  = 4,
    parameter int unsigned SPIN_DIV = 2
) (
    input logic                     vga_clk,
    input logic                     reset_n,
    sonic_motion_anim_ctrl_if.slave bus
);

    anim_state_t      state_q, state_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             facing_q, facing_n;
    logic             key_jump_q;
    logic             jump_req_q, jump_req_n;
    logic [OFS_W-1:0] ofs_x_q, ofs_x_n;
    logic [OFS_W-1:0] ofs_y_q, ofs_y_n;
    logic             jump_edge, req, dir, step;
    logic             launch, reload, land_c, air_ok;
    logic [OFS_W-1:0] jump_pos_y;

    assign jump_edge = bus.key_jump && !key_jump_q;
    assign req       = jump_req_q || jump_edge;
    assign dir       = bus.key_left ^ bus.key_right;
    assign step      = bus.frame_tick && (state_q == JUMP);

`ifdef SONIC_DOUBLE_JUMP_EN
    logic air_jump_used_q;

    // One air jump per flight, re-armed on touchdown
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            air_jump_used_q <= 1'b0;
        end else if (land_c) begin
            air_jump_used_q <= 1'b0;
        end else if (reload) begin
            air_jump_used_q <= 1'b1;
        end
    end

    assign air_ok = !air_jump_used_q;
`else
    assign air_ok = 1'b0;
`endif

    always_comb begin
        state_n    = state_q;
        div_n      = div_q;
        idx_n      = idx_q;
        facing_n   = facing_q;
        jump_req_n = jump_req_q || jump_edge;
        launch     = 1'b0;
        reload     = 1'b0;

        if (bus.frame_tick) begin
            jump_req_n = 1'b0;
            if (bus.key_left && !bus.key_right) begin
                facing_n = 1'b1;
            end else if (bus.key_right && !bus.key_left) begin
                facing_n = 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_n = JUMP;
                        launch  = 1'b1;
                        div_n   = '0;
                        idx_n   = '0;
                    end else if (dir) begin
                        state_n = RUN;
                        div_n   = '0;
                        idx_n   = '0;
                    end
                end
                RUN: begin
                    if (req) begin
                        state_n = JUMP;
                        launch  = 1'b1;
                        div_n   = '0;
                        idx_n   = '0;
                    end else if (!dir) begin
                        state_n = IDLE;
                        div_n   = '0;
                        idx_n   = '0;
                    end else if (div_q == DIV_W'(RUN_DIV - 1)) begin
                        div_n = '0;
                        idx_n = idx_q + IDX_W'(1);
                    end else begin
                        div_n = div_q + DIV_W'(1);
                    end
                end
                JUMP: begin
                    if (land_c) begin
                        state_n = dir ? RUN : IDLE;
                        div_n   = '0;
                        idx_n   = '0;
                    end else if (req && air_ok) begin
                        reload = 1'b1;
                        div_n  = '0;
                        idx_n  = '0;
                    end else if (div_q == DIV_W'(SPIN_DIV - 1)) begin
                        div_n = '0;
                        idx_n = idx_q + IDX_W'(1);
                    end else begin
                        div_n = div_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    div_n   = '0;
                    idx_n   = '0;
                end
            endcase
        end

        // Sheet row follows the state, column follows the frame index
        ofs_x_n = '0;
        ofs_y_n = OFS_W'(ROW_IDLE * FRAME_H);
        case (state_n)
            RUN: begin
                ofs_x_n = OFS_W'(idx_n) * OFS_W'(FRAME_W);
                ofs_y_n = OFS_W'(ROW_RUN * FRAME_H);
            end
            JUMP: begin
                ofs_x_n = OFS_W'(idx_n) * OFS_W'(FRAME_W);
                ofs_y_n = OFS_W'(ROW_JUMP * FRAME_H);
            end
            default: ;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            idx_q      <= '0;
            facing_q   <= 1'b0;
            key_jump_q <= 1'b0;
            jump_req_q <= 1'b0;
            ofs_x_q    <= '0;
            ofs_y_q    <= '0;
        end else begin
            state_q    <= state_n;
            div_q      <= div_n;
            idx_q      <= idx_n;
            facing_q   <= facing_n;
            key_jump_q <= bus.key_jump;
            jump_req_q <= jump_req_n;
            ofs_x_q    <= ofs_x_n;
            ofs_y_q    <= ofs_y_n;
        end
    end

    sonic_jump_physics #(
        .JUMP_VEL (JUMP_VEL),
        .GRAVITY  (GRAVITY)
    ) u_physics (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .step       (step),
        .launch     (launch),
        .reload     (reload),
        .land_c     (land_c),
        .jump_pos_y (jump_pos_y)
    );

    assign bus.sprite_offset_x = ofs_x_q;
    assign bus.sprite_offset_y = ofs_y_q;
    assign bus.jump_pos_y      = jump_pos_y;
    assign bus.facing_left     = facing_q;
    assign bus.anim_state      = state_q;

endmodule

// File: tb/tb_sonic_motion_anim_ctrl.sv
// Bench for sonic_motion_anim_ctrl: directed scenarios plus random keys/ticks
// compared every cycle against a frame-level behavioural model.
module tb_sonic_motion_anim_ctrl;

    localparam int FW   = 18;
    localparam int FH   = 32;
    localparam int JV   = 12;
    localparam int GRAV = 1;
    localparam int RDIV = 4;
    localparam int SDIV = 2;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    bit   chk_en  = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 vga_clk = ~vga_clk;

    sonic_motion_anim_ctrl_if bus ();

    sonic_motion_anim_ctrl dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Model: state 0/1/2, height, velocity, ticks since entering the state/spin
    int m_state, m_pos, m_vel, m_k;
    bit m_face, m_pend, m_prev, m_air;

    function automatic int exp_x();
        int d;
        if (m_state == 0) return 0;
        d = (m_state == 1) ? RDIV : SDIV;
        return ((m_k / d) % 4) * FW;
    endfunction

    function automatic int exp_y();
        return m_state * FH;
    endfunction

    function automatic int exp_jpy();
        if (m_pos < 0) return 0;
        if (m_pos > 1023) return 1023;
        return m_pos;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pin both the DUT and the model to a hand-computed value
    task automatic lit(input string name, input logic [31:0] act, input int mval, input int exp);
        chk({name, " dut"}, act, exp);
        chk({name, " model"}, mval, exp);
    endtask

    task automatic launch_model();
        m_state = 2;
        m_pos   = 0;
        m_vel   = JV;
        m_k     = 0;
        m_air   = 0;
    endtask

    task automatic model_step();
        bit edge_seen, req, dir;
        int nxt;
        if (!reset_n) begin
            m_state = 0; m_pos = 0; m_vel = 0; m_k = 0;
            m_face = 0; m_pend = 0; m_prev = 0; m_air = 0;
            return;
        end
        edge_seen = bus.key_jump && !m_prev;
        m_prev    = bus.key_jump;
        if (!bus.frame_tick) begin
            if (edge_seen) m_pend = 1;
            return;
        end
        req    = m_pend || edge_seen;
        m_pend = 0;
        dir    = bus.key_left ^ bus.key_right;
        if (bus.key_left && !bus.key_right) m_face = 1;
        else if (bus.key_right && !bus.key_left) m_face = 0;
        case (m_state)
            0: begin
                if (req) launch_model();
                else if (dir) begin m_state = 1; m_k = 0; end
            end
            1: begin
                if (req) launch_model();
                else if (!dir) begin m_state = 0; m_k = 0; end
                else m_k++;
            end
            default: begin
                nxt = m_pos + m_vel;
                if (nxt <= 0 && m_vel < 0) begin
                    m_pos = 0; m_vel = 0; m_k = 0; m_air = 0;
                    m_state = dir ? 1 : 0;
                end
`ifdef SONIC_DOUBLE_JUMP_EN
                else if (req && !m_air) begin
                    m_vel = JV; m_k = 0; m_air = 1;
                end
`endif
                else begin
                    m_pos = nxt;
                    m_vel = m_vel - GRAV;
                    m_k++;
                end
            end
        endcase
    endtask

    initial forever begin
        @(posedge vga_clk or negedge reset_n);
        model_step();
    end

    // Every cycle out of reset: DUT outputs against the model
    initial forever begin
        @(negedge vga_clk);
        if (chk_en && reset_n) begin
            chk("ofs_x",  32'(bus.sprite_offset_x), exp_x());
            chk("ofs_y",  32'(bus.sprite_offset_y), exp_y());
            chk("jump_y", 32'(bus.jump_pos_y),      exp_jpy());
            chk("facing", 32'(bus.facing_left),     32'(m_face));
            chk("state",  32'(bus.anim_state),      m_state);
        end
    end

    task automatic cyc(input bit t, input bit l, input bit r, input bit j);
        bus.frame_tick = t;
        bus.key_left   = l;
        bus.key_right  = r;
        bus.key_jump   = j;
        @(negedge vga_clk);
    endtask

    task automatic check_zero(input string tag);
        lit({tag, "_x"},     32'(bus.sprite_offset_x), exp_x(),   0);
        lit({tag, "_y"},     32'(bus.sprite_offset_y), exp_y(),   0);
        lit({tag, "_jy"},    32'(bus.jump_pos_y),      exp_jpy(), 0);
        lit({tag, "_face"},  32'(bus.facing_left),     int'(m_face), 0);
        lit({tag, "_state"}, 32'(bus.anim_state),      m_state,   0);
    endtask

    int run_x [17] = '{0, 0, 0, 0, 18, 18, 18, 18, 36, 36, 36, 36, 54, 54, 54, 54, 0};

    initial begin
        bit l, r, j, t;
        bus.frame_tick = 0;
        bus.key_left   = 0;
        bus.key_right  = 0;
        bus.key_jump   = 0;
        repeat (3) @(negedge vga_clk);
        check_zero("rst");
        reset_n = 1'b1;
        chk_en  = 1'b1;
        cyc(0, 0, 0, 0);

        // Running right: column steps every 4 ticks, row 1
        for (int i = 0; i < 17; i++) begin
            cyc(1, 0, 1, 0);
            lit("run_x", 32'(bus.sprite_offset_x), exp_x(), run_x[i]);
            if (i == 0) begin
                lit("run_state", 32'(bus.anim_state), m_state, 1);
                lit("run_y", 32'(bus.sprite_offset_y), exp_y(), 32);
                lit("run_face", 32'(bus.facing_left), int'(m_face), 0);
            end
            if (i % 2 == 1) cyc(0, 0, 1, 0);
        end

        // Turn left, then both keys: back to idle keeping left facing
        cyc(1, 1, 0, 0);
        lit("left_face", 32'(bus.facing_left), int'(m_face), 1);
        cyc(1, 1, 1, 0);
        lit("both_state", 32'(bus.anim_state), m_state, 0);
        lit("both_x", 32'(bus.sprite_offset_x), exp_x(), 0);
        lit("both_y", 32'(bus.sprite_offset_y), exp_y(), 0);
        lit("both_face", 32'(bus.facing_left), int'(m_face), 1);
        cyc(0, 0, 0, 0);

        // Jump from idle with a second press mid-flight
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        lit("launch_state", 32'(bus.anim_state), m_state, 2);
        lit("launch_jy", 32'(bus.jump_pos_y), exp_jpy(), 0);
        for (int n = 1; n <= 25; n++) begin
            if (n == 5) begin
                cyc(0, 0, 0, 1);
                cyc(0, 0, 0, 0);
            end
            cyc(1, 0, 0, 0);
            if (n == 1) lit("jump_t1", 32'(bus.jump_pos_y), exp_jpy(), 12);
            if (n == 3) lit("jump_y_row", 32'(bus.sprite_offset_y), exp_y(), 64);
`ifndef SONIC_DOUBLE_JUMP_EN
            if (n == 12 || n == 13) lit("jump_peak", 32'(bus.jump_pos_y), exp_jpy(), 78);
            if (n == 24) lit("jump_t24", 32'(bus.jump_pos_y), exp_jpy(), 12);
            if (n == 25) begin
                lit("land_jy", 32'(bus.jump_pos_y), exp_jpy(), 0);
                lit("land_state", 32'(bus.anim_state), m_state, 0);
                lit("land_y", 32'(bus.sprite_offset_y), exp_y(), 0);
            end
`endif
            cyc(0, 0, 0, 0);
        end
        repeat (40) cyc(1, 0, 0, 0);

        // Press on the tick itself, then back-to-back ticks
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        lit("coin_state", 32'(bus.anim_state), m_state, 2);
        lit("coin_jy0", 32'(bus.jump_pos_y), exp_jpy(), 0);
        cyc(1, 0, 0, 1);
        lit("coin_jy1", 32'(bus.jump_pos_y), exp_jpy(), 12);
        cyc(1, 0, 0, 0);
        lit("coin_jy2", 32'(bus.jump_pos_y), exp_jpy(), 23);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        lit("pre_rst_jy", 32'(bus.jump_pos_y), exp_jpy(), 42);

        // Asynchronous reset mid-flight
        #2 reset_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge vga_clk);
        #2 reset_n = 1'b1;
        @(negedge vga_clk);
        cyc(1, 0, 0, 0);
        lit("post_rst_state", 32'(bus.anim_state), m_state, 0);

        // Random keys and ticks with occasional resets
        l = 0; r = 0; j = 0;
        for (int i = 0; i < 6000; i++) begin
            t = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) begin
                l = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 5) == 0) j = !j;
            if ($urandom_range(0, 999) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge vga_clk);
                #2 reset_n = 1'b1;
                @(negedge vga_clk);
            end
            cyc(t, l, r, j);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
